// File: rtl/simplez_pkg.sv
// simplez_pkg: constants and types shared by the Simplez core blocks.
//   ADDR_W        program memory address width (512 words)
//   WORD_W        program memory word width
//   LOAD_HDR      first byte of a serial program-load frame
//   loader_state_t  state encoding of prog_loader, also exported on its
//                   debug port so checkers can bind to it
package simplez_pkg;

  localparam int ADDR_W = 9;
  localparam int WORD_W = 12;

  localparam logic [7:0] LOAD_HDR = 8'h4C;

  typedef enum logic [2:0] {
    LD_IDLE   = 3'd0,
    LD_CNT_HI = 3'd1,
    LD_CNT_LO = 3'd2,
    LD_W_HI   = 3'd3,
    LD_W_LO   = 3'd4,
    LD_FIN    = 3'd5,
    LD_ERR    = 3'd6
  } loader_state_t;

endpackage

// File: rtl/prog_loader.sv
// prog_loader: serial program loader for the Simplez core.
//
// Consumes bytes from the UART receiver, assembles 12-bit words and writes
// them sequentially into the 512x12 program memory starting at address 0.
// While a load is in progress the CPU is held in reset (cpu_hold) so an
// external mux hands the memory write port to this block.
//
// Frame: 0x4C, count-hi, count-lo, then N words as (hi byte, lo byte).
//   {count_hi[0], count_lo} = N-1; hi byte [7:4] must be zero.
//
// Handshake: rx_valid is a one-cycle strobe qualifying rx_data; there is no
// back-pressure, so every strobe is consumed in the cycle it is presented,
// including the cycle in which mem_wr is high.
//
// Optional feature macro: PROG_LOADER_TIMEOUT_EN enables an inter-byte
// timeout of TIMEOUT_CYCLES clk cycles that aborts a stalled frame.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   rx_data      received byte
//   rx_valid     one-cycle strobe, rx_data valid
//   mem_addr     memory write address
//   mem_data     memory write data
//   mem_wr       one-cycle write strobe
//   cpu_hold     1 = CPU held in reset, memory owned by loader
//   busy         frame in progress (state != IDLE)
//   done         one-cycle pulse after the final write
//   error        sticky, last frame aborted
//   state        debug view of the FSM state
module prog_loader
  import simplez_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 12_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_data,
  output logic              mem_wr,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output loader_state_t     state
);

  logic [ADDR_W-1:0] last_addr;
  logic              cnt_msb;
  logic [3:0]        hi_nib;

`ifdef PROG_LOADER_TIMEOUT_EN
  logic [31:0] tmo_cnt;
`endif

  assign busy = (state != LD_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LD_IDLE;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_wr    <= 1'b0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      last_addr <= '0;
      cnt_msb   <= 1'b0;
      hi_nib    <= '0;
`ifdef PROG_LOADER_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      done <= 1'b0;

      // The write cycle ends here; advance to the next word slot.
      if (mem_wr) begin
        mem_wr   <= 1'b0;
        mem_addr <= mem_addr + ADDR_W'(1);
      end

      case (state)
        LD_IDLE: begin
          if (rx_valid && rx_data == LOAD_HDR) begin
            state    <= LD_CNT_HI;
            cpu_hold <= 1'b1;
            error    <= 1'b0;
            mem_addr <= '0;
          end
        end
        LD_CNT_HI: begin
          if (rx_valid) begin
            cnt_msb <= rx_data[0];
            state   <= LD_CNT_LO;
          end
        end
        LD_CNT_LO: begin
          if (rx_valid) begin
            last_addr <= {cnt_msb, rx_data};
            state     <= LD_W_HI;
          end
        end
        LD_W_HI: begin
          if (rx_valid) begin
            if (rx_data[7:4] != 4'd0) begin
              state <= LD_ERR;
            end else begin
              hi_nib <= rx_data[3:0];
              state  <= LD_W_LO;
            end
          end
        end
        LD_W_LO: begin
          // mem_addr is stable here: the previous write cycle has already
          // ended, so it points at the slot this word goes to.
          if (rx_valid) begin
            mem_data <= {hi_nib, rx_data};
            mem_wr   <= 1'b1;
            state    <= (mem_addr == last_addr) ? LD_FIN : LD_W_HI;
          end
        end
        LD_FIN: begin
          done     <= 1'b1;
          cpu_hold <= 1'b0;
          state    <= LD_IDLE;
        end
        LD_ERR: begin
          // cpu_hold is left high so a partial program never runs.
          error <= 1'b1;
          state <= LD_IDLE;
        end
        default: state <= LD_IDLE;
      endcase

`ifdef PROG_LOADER_TIMEOUT_EN
      // Reload on every byte (header included); count down only while a
      // frame is open. A strobe in the expiry cycle still wins.
      if (rx_valid) begin
        tmo_cnt <= TIMEOUT_CYCLES;
      end else if (state != LD_IDLE && tmo_cnt != 32'd0) begin
        tmo_cnt <= tmo_cnt - 32'd1;
      end
      if (!rx_valid && tmo_cnt == 32'd0 &&
          (state == LD_CNT_HI || state == LD_CNT_LO ||
           state == LD_W_HI   || state == LD_W_LO)) begin
        state <= LD_ERR;
      end
`endif
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: self-checking bench for prog_loader.
// Frames are built from word lists; expected memory writes are queued as
// {addr, data} when a frame is issued and popped by a negedge monitor.
module tb_prog_loader;
  import simplez_pkg::*;

  localparam int unsigned TMO = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_data;
  logic              mem_wr;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;
  loader_state_t     state;

  prog_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_wr   (mem_wr),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .state    (state)
  );

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [ADDR_W+WORD_W-1:0] exp_q[$];
  int done_cnt = 0;
  int overlap_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (mem_wr && rx_valid) overlap_cnt++;
      if (mem_wr) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_data);
        end else begin
          logic [ADDR_W+WORD_W-1:0] e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(e[ADDR_W+WORD_W-1:WORD_W]));
          check("wr_data", 32'(mem_data), 32'(e[WORD_W-1:0]));
          check("wr_hold", 32'(cpu_hold), 32'd1);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom_range(0, 255));
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_reached", 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  // Reference model at frame level: a good frame writes word i to address
  // i for every word; a frame aborted at word k writes only words 0..k-1.
  task automatic send_frame(input logic [WORD_W-1:0] words[$], input int bad_at,
                            input int gmin, input int gmax);
    int n;
    logic [8:0] cnt;
    logic [6:0] junk;
    logic [7:0] b;
    int writes;
    n = words.size();
    cnt = 9'(n - 1);
    junk = 7'($urandom_range(0, 127));
    done_cnt = 0;
    writes = n;
    send_byte(LOAD_HDR, $urandom_range(gmin, gmax));
    check("hdr_hold", 32'(cpu_hold), 32'd1);
    check("hdr_err_clear", 32'(error), 32'd0);
    check("hdr_busy", 32'(busy), 32'd1);
    send_byte({junk, cnt[8]}, $urandom_range(gmin, gmax));
    send_byte(cnt[7:0], $urandom_range(gmin, gmax));
    for (int i = 0; i < n; i++) begin
      if (i == bad_at) begin
        b = {4'($urandom_range(1, 15)), 4'($urandom_range(0, 15))};
        if (i == 2) b = 8'h1F;
        writes = i;
        send_byte(b, $urandom_range(gmin, gmax));
        break;
      end
      exp_q.push_back({9'(i), words[i]});
      send_byte({4'd0, words[i][11:8]}, $urandom_range(gmin, gmax));
      send_byte(words[i][7:0], $urandom_range(gmin, gmax));
    end
    wait_idle();
    check("frame_writes_left", 32'(exp_q.size()), 32'd0);
    check("frame_done_cnt", 32'(done_cnt), (bad_at < 0) ? 32'd1 : 32'd0);
    check("frame_hold", 32'(cpu_hold), (bad_at < 0) ? 32'd0 : 32'd1);
    check("frame_error", 32'(error), (bad_at < 0) ? 32'd0 : 32'd1);
    check("frame_addr_after", 32'(mem_addr), 32'(9'(writes)));
    exp_q.delete();
  endtask

  function automatic void rand_words(ref logic [WORD_W-1:0] q[$], input int n);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(12'($urandom_range(0, 4095)));
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [WORD_W-1:0] w[$];

    // Reset values
    #12;
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_data", 32'(mem_data), 32'd0);
    check("rst_wr", 32'(mem_wr), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_state", 32'(state), 32'(LD_IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Non-header bytes in IDLE are ignored
    for (int i = 0; i < 6; i++) begin
      logic [7:0] jb;
      jb = 8'($urandom_range(0, 255));
      if (jb == LOAD_HDR) jb = 8'h00;
      send_byte(jb, $urandom_range(0, 2));
    end
    check("idle_ignore_busy", 32'(busy), 32'd0);
    check("idle_ignore_hold", 32'(cpu_hold), 32'd0);

    // Directed N=3: 12'o1006, 12'o0100, 12'o7000
    w = '{12'o1006, 12'o0100, 12'o7000};
    send_frame(w, -1, 0, 2);

    // Header byte value appearing as data
    w = '{12'h04C, 12'h34C, 12'h000, 12'hFFF};
    send_frame(w, -1, 0, 1);

    // Randomised frames with random gaps (0 = back-to-back)
    for (int f = 0; f < 6; f++) begin
      rand_words(w, $urandom_range(1, 40));
      send_frame(w, -1, 0, 3);
    end

    // Bad hi byte 0x1F at word 2, then a valid frame clears error
    rand_words(w, 5);
    send_frame(w, 2, 0, 2);
    rand_words(w, 3);
    send_frame(w, -1, 0, 2);

    // Random abort point
    rand_words(w, 6);
    send_frame(w, $urandom_range(0, 5), 0, 1);

    // Full 512-word load, every cycle carries a byte
    overlap_cnt = 0;
    rand_words(w, 512);
    send_frame(w, -1, 0, 0);
    check("b2b_overlap_seen", 32'(overlap_cnt > 0), 32'd1);

    // Asynchronous reset mid-frame after the second word
    done_cnt = 0;
    rand_words(w, 5);
    send_byte(LOAD_HDR, 0);
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({9'(i), w[i]});
      send_byte({4'd0, w[i][11:8]}, 0);
      send_byte(w[i][7:0], 1);
    end
    send_byte({4'd0, w[2][11:8]}, 0);
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_writes_left", 32'(exp_q.size()), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_addr", 32'(mem_addr), 32'd0);
    check("arst_data", 32'(mem_data), 32'd0);
    check("arst_wr", 32'(mem_wr), 32'd0);
    check("arst_hold", 32'(cpu_hold), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_error", 32'(error), 32'd0);
    check("arst_state", 32'(state), 32'(LD_IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rand_words(w, 4);
    send_frame(w, -1, 0, 2);

`ifdef PROG_LOADER_TIMEOUT_EN
    // Stall of more than TMO cycles in W_LO aborts the frame
    done_cnt = 0;
    send_byte(LOAD_HDR, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h05, 0);
    repeat (TMO + 10) begin @(posedge clk); #1; end
    check("tmo_error", 32'(error), 32'd1);
    check("tmo_hold", 32'(cpu_hold), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_done", 32'(done_cnt), 32'd0);

    // 99-cycle gaps stay within the timeout
    rand_words(w, 2);
    send_frame(w, -1, int'(TMO) - 1, int'(TMO) - 1);
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Serial program loader for the Simplez core: consumes bytes from the UART receiver, assembles 12-bit words and writes them sequentially into the 512×12 program memory starting at address 0. It sits upstream of the memory's write port and holds the CPU in reset while loading. An external mux selects the loader or the CPU as memory master using `cpu_hold`. After reset the CPU runs whatever memory already holds; a load replaces it.

## Interface
- `TIMEOUT_CYCLES`, default 12_000_000: inter-byte timeout in clk cycles (1 s at 12 MHz). Used only with `PROG_LOADER_TIMEOUT_EN`.
- `clk` in 1: system clock; all loader logic on posedge.
- `rst` in 1: reset, asynchronous, active-high.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe, `rx_data` valid.
- `mem_addr` out 9: memory write address.
- `mem_data` out 12: memory write data.
- `mem_wr` out 1: write strobe, one cycle.
- `cpu_hold` out 1: 1 = CPU held in reset, memory owned by loader.
- `busy` out 1: load frame in progress.
- `done` out 1: one-cycle pulse, load completed.
- `error` out 1: sticky, last frame aborted.

## Operation
- Frame: header `8'h4C`, count-hi byte, count-lo byte, then N words of two bytes each, hi byte then lo byte.
- Count field: `{cnt_hi[0], cnt_lo}` = N−1, so N = 1..512. `cnt_hi[7:1]` are ignored.
- Word hi byte: `[3:0]` = word[11:8]; `[7:4]` must be 0. Lo byte = word[7:0].
- States:
  - IDLE: `rx_valid` with `8'h4C` → CNT_HI; sets `cpu_hold`=1, clears `error`, `mem_addr`=0. Any other byte is ignored.
  - CNT_HI: byte → CNT_LO.
  - CNT_LO: byte → W_HI; stores last address = count field.
  - W_HI: byte with `[7:4]`≠0 → ERR; otherwise latch the nibble → W_LO.
  - W_LO: byte → `mem_data` registered, `mem_wr`=1 next cycle.
    - If `mem_addr` ≠ last: next state W_HI.
    - Else: next state FIN.
- After each write cycle, `mem_addr` increments (9-bit). It never wraps within a frame, since last ≤ 511.
- FIN: one cycle. `done`=1, `cpu_hold`=0, → IDLE.
- ERR: one cycle. `error`=1, → IDLE. `cpu_hold` stays 1 until the next successful load or `rst`, so a partial program never runs.
- `busy` = state ∉ {IDLE}.
- A header byte received mid-frame is treated as data; there is no resynchronisation except via error or timeout.

## Timing
- Reset values: `mem_addr`=0, `mem_data`=0, `mem_wr`=0, `cpu_hold`=0, `busy`=0, `done`=0, `error`=0, state IDLE.
- `mem_wr` is asserted posedge to posedge, exactly one cycle, the cycle after the lo byte's `rx_valid`. `mem_addr`/`mem_data` are stable for that whole cycle, so the memory's negedge write samples mid-cycle.
- `mem_addr` increments on the posedge ending the write cycle.
- `rx_valid` in the same cycle as `mem_wr` (W_HI state) is accepted; no byte is ever dropped. Back-to-back `rx_valid` on consecutive cycles must be handled.
- `done` is asserted in the cycle after the final `mem_wr`.
- `rst` mid-frame: immediate return to reset values. `cpu_hold` drops, and memory keeps the partially written contents.

## Configuration
- `PROG_LOADER_TIMEOUT_EN` defined:
  - A down-counter reloads to `TIMEOUT_CYCLES` on every `rx_valid` and on header acceptance.
  - Reaching 0 in any state other than IDLE → ERR.
  - The counter is idle in IDLE.
- Undefined: no counter, no timeout; the loader waits indefinitely. `TIMEOUT_CYCLES` is unused.

## Structure
- Shared package `simplez_pkg`: `ADDR_W`=9, `WORD_W`=12, `LOAD_HDR`=8'h4C, loader state enum.
- Single module. The timeout counter stays inline behind the macro, with no sub-module.

## Test plan
- Load N=3, words 12'o1006, 12'o0100, 12'o7000:
  - Bytes 4C,00,02,02,06,00,40,0E,00.
  - Expect `mem_wr` at addr 0,1,2 with those data, `done` pulse, `cpu_hold` 1→0.
- Full load N=512: count bytes 01,FF.
  - Expect 512 writes, last at addr 511, no wrap, `done` once.
- Bad hi byte 0x1F at word 2:
  - Expect `error`=1, no further writes, `cpu_hold` stays 1.
  - A subsequent valid frame clears `error`.
- Back-to-back `rx_valid` every cycle:
  - No byte is lost.
  - `mem_wr` overlaps acceptance of the next hi byte.
- `rst` asserted after the second word: all outputs return to reset values asynchronously, and the next header starts cleanly at addr 0.
- With `PROG_LOADER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100:
  - A stall of 101 cycles in W_LO gives ERR.
  - 99-cycle gaps complete normally.
